mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Round-robin arbiter that shares one 32-bit memory port between four requesters (e.g. instruction fetch, load/store, debug, DMA). It owns the 2-bit select of the shared 4:1 32-bit data mux in front of the port. It sequences one transaction at a time with a valid/ready handshake toward memory, and guards each transaction with a timeout watchdog.

## Interface
- TIMEOUT_CYCLES, default 255: maximum cycles mem_valid may stay high without mem_ready; range 1..65535.

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  4  per-requester request; bit i = requester i
- grant  out  4  one-hot owner of the port; all zero when idle
- sel  out  2  select for the shared 4:1 data mux; encodes the owner index
- mem_valid  out  1  transaction request to memory
- mem_ready  in  1  memory completion; sampled only while mem_valid=1
- done  out  4  one-cycle pulse on bit i when requester i's transaction completes
- timeout  out  1  one-cycle pulse when a transaction is aborted by the watchdog
- busy  out  1  high in REQ state

## Operation
- State machine with two states: IDLE and REQ.
- Internal state: owner (2 bits), last (2 bits, last serviced index), wd counter (width clog2(TIMEOUT_CYCLES+1)).
- IDLE:
  - If req != 0, pick the first set bit scanning last+1, last+2, last+3, last (mod 4).
  - Load owner/sel with that index, set grant one-hot, clear wd, go to REQ.
  - If req == 0, stay in IDLE; grant=0, mem_valid=0, sel holds its previous value.
- REQ:
  - mem_valid=1, busy=1, grant and sel stable.
  - On mem_ready=1: pulse done[owner], set last=owner, grant=0, go to IDLE.
  - Else if wd == TIMEOUT_CYCLES-1: pulse timeout, no done, set last=owner, grant=0, go to IDLE.
  - Else wd increments.
- If mem_ready and the timeout condition coincide, mem_ready wins: done pulses and timeout does not.
- req changes during REQ are ignored. A transaction always finishes or times out, even if the owner drops req.
- Requesters hold req until their done. A requester still holding req after done competes again with rotated priority.
- mem_ready while in IDLE is ignored.

## Timing
- All outputs are registered.
- Reset values (async on rst_n low): state=IDLE, grant=0, sel=0, mem_valid=0, busy=0, done=0, timeout=0, last=3 (requester 0 has first priority), wd=0.
- Grant latency: req sampled at edge N in IDLE; grant/sel/mem_valid are high from edge N to N+1.
- Completion: mem_ready high in cycle K (mem_valid high); at edge K+1, done is high for exactly one cycle and grant/mem_valid/busy drop.
- Minimum transaction: mem_valid high 1 cycle. Minimum spacing is 1 IDLE cycle between transactions, so peak is one transaction per 2 cycles.
- Timeout: mem_valid stays high exactly TIMEOUT_CYCLES cycles, then timeout pulses one cycle and mem_valid drops on the same edge.
- Fairness: with all four req high continuously, grants are issued in order 0,1,2,3,0,... Worst-case wait is 3 transactions.
- Reset asserted mid-REQ: mem_valid and grant drop immediately (asynchronously); no done or timeout is generated. After release, the block resumes from IDLE with last=3.
- sel changes only on the IDLE->REQ edge, so mux output is stable for the whole of mem_valid.

## Test plan
- Reset then req=4'b0001, mem_ready high one cycle after mem_valid -> grant=0001, sel=0, mem_valid high 2 cycles, done=0001 pulse, busy returns 0.
- req=4'b1111 held, mem_ready tied high -> grant sequence 0001,0010,0100,1000,0001 with one IDLE cycle between; sel follows 0,1,2,3,0.
- TIMEOUT_CYCLES=4, req=4'b0100, mem_ready=0 -> mem_valid high exactly 4 cycles, timeout pulses once, done stays 0, next grant goes to next requester after 2.
- mem_ready rises in the same cycle wd reaches TIMEOUT_CYCLES-1 -> done pulses, timeout stays 0.
- Owner drops req mid-REQ while req=4'b1010 pending -> transaction completes with done for owner; next grant follows round-robin from that owner.
- rst_n pulsed low during REQ -> grant/mem_valid/busy go 0 without a clock edge, no done/timeout; after release with req=4'b1000 plus 4'b0001 -> requester 0 is granted first.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundles the requester-side and memory-side signals of the shared memory port.
// The arbiter uses the master modport; the environment uses the slave modport.
interface mem_port_arbiter_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       mem_valid;
    logic       mem_ready;
    logic [3:0] done;
    logic       timeout;
    logic       busy;

    modport master (
        input  req, mem_ready,
        output grant, sel, mem_valid, done, timeout, busy
    );

    modport slave (
        output req, mem_ready,
        input  grant, sel, mem_valid, done, timeout, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for one shared memory port across four requesters.
// Runs one valid/ready transaction at a time, each guarded by a timeout watchdog.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.master bus
);
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, REQ} state_e;

    state_e          state_q, state_d;
    logic [1:0]      owner_q, owner_d;
    logic [1:0]      last_q, last_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [3:0]      grant_q, grant_d;
    logic [3:0]      done_q, done_d;
    logic            timeout_q, timeout_d;

    logic [1:0]      pick;
    logic            pick_vld;
    logic [1:0]      idx;

    // Scan from lowest to highest priority so the closest hit after last wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int i = 4; i >= 1; i--) begin
            idx = last_q + 2'(i);
            if (bus.req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        wd_d      = wd_q;
        grant_d   = grant_q;
        done_d    = '0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    owner_d = pick;
                    grant_d = 4'b0001 << pick;
                    wd_d    = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // A completion in the same cycle as the watchdog limit still counts as done.
                if (bus.mem_ready) begin
                    done_d  = 4'b0001 << owner_q;
                    last_d  = owner_q;
                    grant_d = '0;
                    state_d = IDLE;
                end else if (wd_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    last_d    = owner_q;
                    grant_d   = '0;
                    state_d   = IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            last_q    <= 2'd3;
            wd_q      <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            wd_q      <= wd_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    // owner only changes on IDLE->REQ, so the mux select is stable for the whole transaction.
    assign bus.grant     = grant_q;
    assign bus.sel       = owner_q;
    assign bus.mem_valid = (state_q == REQ);
    assign bus.busy      = (state_q == REQ);
    assign bus.done      = done_q;
    assign bus.timeout   = timeout_q;
endmodule
